// File: rtl/adc_capture_fifo_if.sv
// Signal bundle between the ADC capture/FIFO block and its surroundings:
// the sequencer request, the chip-side serial pins and the host read port.
interface adc_capture_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              sample_req;
  logic              clear;
  logic              ADC_OUT;
  logic              CLK_S_D_OUT;
  logic              busy;
  logic              adc_out_rd;
  logic [31:0]       data_out_adc;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              missed;

  modport master (
    input  sample_req, clear, ADC_OUT, adc_out_rd,
    output CLK_S_D_OUT, busy, data_out_adc, empty, full, count, overflow, missed
  );

  modport slave (
    output sample_req, clear, ADC_OUT, adc_out_rd,
    input  CLK_S_D_OUT, busy, data_out_adc, empty, full, count, overflow, missed
  );
endinterface

// File: rtl/adc_capture_fifo.sv
// Clocks one serial word out of the chip ADC per sample request and queues it
// in a first-word-fall-through FIFO for the host, flagging dropped and missed samples.
module adc_capture_fifo #(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  adc_capture_fifo_if.master  bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, LO, HI, PUSH} state_t;

  state_t            state, state_next;
  logic [DIV_W-1:0]  div_cnt, div_next;
  logic [BIT_W-1:0]  bit_cnt, bit_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              push;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic [ADDR_W:0]   count;
  logic [31:0]       head, head_next;
  logic              pop, push_ok, is_full, is_empty;
  logic              overflow, missed;
  logic              flush;

  assign flush = rst || bus.clear;

  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sample_req) begin
          state_next = LO;
          div_next   = '0;
          bit_next   = '0;
          shift_next = '0;
        end
      end
      LO: begin
        if (div_cnt == DIV_LAST) begin
          state_next = HI;
          div_next   = '0;
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      HI: begin
        // the ADC bit is taken once, on the first cycle after the rising edge
        if (div_cnt == '0) begin
          shift_next = (shift_reg << 1) | DATA_W'(bus.ADC_OUT);
        end
        if (div_cnt == DIV_LAST) begin
          div_next = '0;
          if (bit_cnt == BIT_LAST) begin
            state_next = PUSH;
          end else begin
            bit_next   = bit_cnt + BIT_W'(1);
            state_next = LO;
          end
        end else begin
          div_next = div_cnt + DIV_W'(1);
        end
      end
      PUSH: begin
        push       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      div_cnt   <= div_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  assign is_full    = (count == DEPTH_CNT);
  assign is_empty   = (count == '0);
  assign pop        = bus.adc_out_rd && !is_empty;
  assign push_ok    = push && (!is_full || pop);
  assign rd_ptr_inc = rd_ptr + ADDR_W'(1);

  // The head register always mirrors the oldest stored word; when the FIFO
  // drains it simply keeps the last word shown.
  always_comb begin
    head_next = head;
    if (pop && (count != CNT_ONE)) begin
      head_next = 32'(mem[rd_ptr_inc]);
    end else if (push_ok && (is_empty || pop)) begin
      head_next = 32'(shift_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= shift_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      overflow <= 1'b0;
      missed   <= 1'b0;
    end else begin
      head <= head_next;
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      if (push_ok && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push_ok) begin
        count <= count - CNT_ONE;
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      if (bus.sample_req && (state != IDLE)) begin
        missed <= 1'b1;
      end
    end
  end

  assign bus.CLK_S_D_OUT  = (state == HI);
  assign bus.busy         = (state != IDLE);
  assign bus.data_out_adc = head;
  assign bus.empty        = is_empty;
  assign bus.full         = is_full;
  assign bus.count        = count;
  assign bus.overflow     = overflow;
  assign bus.missed       = missed;

endmodule

// File: tb/tb_adc_capture_fifo.sv
// Bench for adc_capture_fifo: a serial ADC model, a queue-based reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_adc_capture_fifo;

  localparam int DATA_W     = 16;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int ADDR_W     = 4;
  localparam int FRAME      = 2 * CLK_DIV * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adc_capture_fifo_if #(.ADDR_W(ADDR_W)) bus();

  adc_capture_fifo #(
    .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [DATA_W-1:0] tx_word = '0;
  int rises        = 0;
  int high_cycles  = 0;
  int r0, h0;
  bit go;
  int rd_mod;

  // reference model: a word queue plus a countdown for the frame in flight
  logic [31:0]       m_q[$];
  logic [31:0]       m_head   = '0;
  bit                m_ovf    = 1'b0;
  bit                m_missed = 1'b0;
  bit                m_busy   = 1'b0;
  int                m_left   = 0;
  logic [DATA_W-1:0] m_word   = '0;
  bit                m_push, m_pop, exp_sclk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk);
      if (rst || bus.clear) begin
        m_q.delete();
        m_head   = '0;
        m_ovf    = 1'b0;
        m_missed = 1'b0;
        m_busy   = 1'b0;
        m_left   = 0;
      end else begin
        m_push = m_busy && (m_left == 0);
        m_pop  = bus.adc_out_rd && (m_q.size() > 0);
        if (m_pop) void'(m_q.pop_front());
        if (m_push) begin
          if (m_q.size() < FIFO_DEPTH) m_q.push_back(32'(m_word));
          else m_ovf = 1'b1;
        end
        if (m_q.size() > 0) m_head = m_q[0];
        if (m_busy) begin
          if (bus.sample_req) m_missed = 1'b1;
          if (m_left == 0) m_busy = 1'b0;
          else m_left--;
        end else if (bus.sample_req) begin
          m_busy = 1'b1;
          m_left = FRAME;
          m_word = tx_word;
        end
      end
    end
  endtask

  // chip ADC: presents the next MSB-first bit of tx_word on every shift-clock rise
  task automatic adc_loop();
    bit prev = 1'b0;
    int bitpos = 0;
    forever begin
      @(negedge clk);
      if (bus.busy !== 1'b1) bitpos = 0;
      if (bus.CLK_S_D_OUT === 1'b1 && !prev) begin
        bus.ADC_OUT = (bitpos < DATA_W) ? tx_word[DATA_W-1-bitpos] : 1'b0;
        bitpos++;
        rises++;
      end
      if (bus.CLK_S_D_OUT === 1'b1) high_cycles++;
      prev = (bus.CLK_S_D_OUT === 1'b1);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        exp_sclk = m_busy && (m_left > 0) && ((((FRAME - m_left) / CLK_DIV) % 2) == 1);
        check_output("sclk",     bus.CLK_S_D_OUT,  32'(exp_sclk));
        check_output("busy",     bus.busy,         32'(m_busy));
        check_output("empty",    bus.empty,        32'(m_q.size() == 0));
        check_output("full",     bus.full,         32'(m_q.size() == FIFO_DEPTH));
        check_output("count",    bus.count,        32'(m_q.size()));
        check_output("overflow", bus.overflow,     32'(m_ovf));
        check_output("missed",   bus.missed,       32'(m_missed));
        check_output("data",     bus.data_out_adc, m_head);
      end
    end
  endtask

  task automatic apply_stimulus(input logic [DATA_W-1:0] w);
    tx_word        = w;
    bus.sample_req = 1'b1;
    @(negedge clk);
    bus.sample_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < FRAME + 20) begin
      @(negedge clk);
      n++;
    end
    check_output("idle_timeout", bus.busy, 32'd0);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  initial begin
    bus.sample_req = 1'b0;
    bus.clear      = 1'b0;
    bus.adc_out_rd = 1'b0;
    bus.ADC_OUT    = 1'b0;
    fork
      model_loop();
      adc_loop();
      compare_loop();
    join_none

    repeat (3) @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    check_output("rst_sclk",  bus.CLK_S_D_OUT,  32'd0);
    check_output("rst_busy",  bus.busy,         32'd0);
    check_output("rst_empty", bus.empty,        32'd1);
    check_output("rst_count", bus.count,        32'd0);
    check_output("rst_data",  bus.data_out_adc, 32'd0);

    // single frame: word appears exactly at cycle 1 + FRAME + 1
    r0 = rises;
    h0 = high_cycles;
    apply_stimulus(16'hA5C3);
    repeat (FRAME) @(negedge clk);
    check_output("single_pre_empty", bus.empty, 32'd1);
    @(negedge clk);
    check_output("single_data",   bus.data_out_adc, 32'h0000A5C3);
    check_output("single_count",  bus.count,        32'd1);
    check_output("single_pulses", 32'(rises - r0),       32'd16);
    check_output("single_hicyc",  32'(high_cycles - h0), 32'd64);
    check_output("model_single",  m_head,               32'h0000A5C3);

    do_clear();
    check_output("clear_empty", bus.empty,        32'd1);
    check_output("clear_data",  bus.data_out_adc, 32'd0);

    // fill past capacity without reading
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(DATA_W'(16'h1000 + i));
      wait_idle();
    end
    @(negedge clk);
    check_output("fill_full",  bus.full,         32'd1);
    check_output("fill_count", bus.count,        32'd16);
    check_output("fill_ovf",   bus.overflow,     32'd1);
    check_output("fill_head",  bus.data_out_adc, 32'h00001000);
    check_output("model_fill", 32'(m_q.size()),  32'd16);

    // full FIFO with pop during the PUSH cycle
    do_clear();
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(DATA_W'(16'h2000 + i));
      wait_idle();
    end
    apply_stimulus(16'h2010);
    repeat (FRAME) @(negedge clk);
    bus.adc_out_rd = 1'b1;
    @(negedge clk);
    bus.adc_out_rd = 1'b0;
    check_output("pp_count", bus.count,        32'd16);
    check_output("pp_ovf",   bus.overflow,     32'd0);
    check_output("pp_full",  bus.full,         32'd1);
    check_output("pp_head",  bus.data_out_adc, 32'h00002001);

    // request while busy
    do_clear();
    r0 = rises;
    apply_stimulus(16'h5A3C);
    repeat (38) @(negedge clk);
    bus.sample_req = 1'b1;
    @(negedge clk);
    bus.sample_req = 1'b0;
    wait_idle();
    @(negedge clk);
    check_output("busy_missed", bus.missed,          32'd1);
    check_output("busy_count",  bus.count,           32'd1);
    check_output("busy_head",   bus.data_out_adc,    32'h00005A3C);
    check_output("busy_pulses", 32'(rises - r0),     32'd16);

    // reset in the middle of a frame
    do_clear();
    apply_stimulus(16'h1234);
    repeat (59) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("mid_rst_sclk",  bus.CLK_S_D_OUT, 32'd0);
    check_output("mid_rst_busy",  bus.busy,        32'd0);
    check_output("mid_rst_count", bus.count,       32'd0);
    repeat (FRAME + 10) @(negedge clk);
    check_output("mid_rst_nopush", bus.count,      32'd0);

    // drain three words with four reads
    apply_stimulus(16'h0111); wait_idle();
    apply_stimulus(16'h0222); wait_idle();
    apply_stimulus(16'h0333); wait_idle();
    @(negedge clk);
    check_output("drain_head0", bus.data_out_adc, 32'h00000111);
    bus.adc_out_rd = 1'b1; @(negedge clk); bus.adc_out_rd = 1'b0;
    check_output("drain_head1", bus.data_out_adc, 32'h00000222);
    bus.adc_out_rd = 1'b1; @(negedge clk); bus.adc_out_rd = 1'b0;
    check_output("drain_head2", bus.data_out_adc, 32'h00000333);
    bus.adc_out_rd = 1'b1; @(negedge clk); bus.adc_out_rd = 1'b0;
    bus.adc_out_rd = 1'b1; @(negedge clk); bus.adc_out_rd = 1'b0;
    check_output("drain_empty", bus.empty,    32'd1);
    check_output("drain_count", bus.count,    32'd0);
    check_output("drain_ovf",   bus.overflow, 32'd0);
    check_output("drain_hold",  bus.data_out_adc, 32'h00000333);

    // random traffic: slow reads first so the FIFO fills, then fast reads
    do_clear();
    for (int i = 0; i < 6000; i++) begin
      rd_mod = (i < 3500) ? 300 : 4;
      go = (($urandom % 40) == 0);
      bus.adc_out_rd = (($urandom % rd_mod) == 0);
      bus.clear      = (($urandom % 1500) == 0);
      if (go && !m_busy) tx_word = DATA_W'($urandom);
      bus.sample_req = go;
      @(negedge clk);
    end
    bus.sample_req = 1'b0;
    bus.adc_out_rd = 1'b0;
    bus.clear      = 1'b0;
    repeat (FRAME + 10) @(negedge clk);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
